cond_unit: RTL

- Conditional-execution back end of the multicycle control path. It consumes the decoder's control intents (PCS, RegW, MemW, NoWrite, FlagW, NextPC, IRWrite) and produces the architectural write enables PCWrite, RegWrite and MemWrite.
- Holds the NZCV flag register and evaluates the 4-bit ARM condition field once per instruction, in the decode cycle.
- Latches the pass/fail result so that flag updates made during execute cannot change the outcome mid-instruction.
- Keeps saturating executed/squashed instruction counters for bring-up and performance debug.

---
 rtl/cond_unit_if.sv | 33 +++
 rtl/cond_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/cond_unit_if.sv
// Control-intent and gated-enable bundle between the multicycle decoder FSM
// and the conditional-execution unit.
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             IRWrite;
  logic             CntClr;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             CondEx_q;
  logic [CNT_W-1:0] RetireCount;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite, IRWrite, CntClr,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx_q, RetireCount, SquashCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite, IRWrite, CntClr,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx_q, RetireCount, SquashCount
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution back end: NZCV register, once-per-instruction condition
// latch, gated PC/register/memory write enables and retire/squash counters.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       Reset,
  cond_unit_if.slave cu
);

  logic [3:0]       flags_q;
  logic             condex_q;
  logic             dec_q;
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] squash_q;
  logic             cc;

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cc = 1'b0;
    case (cu.Cond)
      4'b0000: cc = z_f;
      4'b0001: cc = ~z_f;
      4'b0010: cc = c_f;
      4'b0011: cc = ~c_f;
      4'b0100: cc = n_f;
      4'b0101: cc = ~n_f;
      4'b0110: cc = v_f;
      4'b0111: cc = ~v_f;
      4'b1000: cc = c_f & ~z_f;
      4'b1001: cc = ~c_f | z_f;
      4'b1010: cc = (n_f == v_f);
      4'b1011: cc = (n_f != v_f);
      4'b1100: cc = ~z_f & (n_f == v_f);
      4'b1101: cc = z_f | (n_f != v_f);
      4'b1110: cc = 1'b1;
      default: cc = 1'b0;
    endcase
  end

  // Flag writes are qualified by the pre-edge condex_q, so a decode-cycle
  // latch and a flag update in the same cycle never see each other.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
      dec_q    <= 1'b0;
      retire_q <= '0;
      squash_q <= '0;
    end else begin
      dec_q <= cu.IRWrite;
      if (dec_q)
        condex_q <= cc;
      if (cu.FlagW[1] && condex_q)
        flags_q[3:2] <= cu.ALUFlags[3:2];
      if (cu.FlagW[0] && condex_q)
        flags_q[1:0] <= cu.ALUFlags[1:0];
      if (cu.CntClr) begin
        retire_q <= '0;
        squash_q <= '0;
      end else if (dec_q) begin
        if (cc) begin
          if (retire_q != '1)
            retire_q <= retire_q + 1'b1;
        end else begin
          if (squash_q != '1)
            squash_q <= squash_q + 1'b1;
        end
      end
    end
  end

  assign cu.PCWrite     = (cu.PCS & condex_q) | cu.NextPC;
  assign cu.RegWrite    = cu.RegW & condex_q & ~cu.NoWrite;
  assign cu.MemWrite    = cu.MemW & condex_q;
  assign cu.Flags       = flags_q;
  assign cu.CondEx_q    = condex_q;
  assign cu.RetireCount = retire_q;
  assign cu.SquashCount = squash_q;

endmodule
